// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronises rx_serial, samples each bit at mid-period,
// and emits one rx_valid or frame_error pulse per frame.
module uart_rx_frame #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!rx_sync) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rx_sync) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          // A held-low line must not be mistaken for a new start bit.
          if (rx_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: line-level frame scheduler model plus literal
// per-scenario expectations, with 16 clocks per bit.
module tb_uart_rx_frame;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  // Pulse cycle relative to the cycle the start bit is driven:
  // 2 synchroniser cycles + 1 detect edge + half bit + 9 full bits.
  localparam int PULSE_OFS = 3 + HALF + 9 * CPB;

  typedef struct {
    int         at;
    bit         err;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  int n_valid = 0;
  int n_ferr = 0;
  bit check_en = 1'b0;
  bit rst_was = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic exp_valid, exp_ferr, exp_busy;
  ev_t ev_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx_frame #(.CLK_FREQ_HZ(16), .BAUD_RATE(1)) dut (
    .clk(clk),
    .rst(rst),
    .rx_serial(rx_serial),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one full 8N1 frame and schedule the pulse it must produce.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    ev_t e;
    int c;
    c = cyc;
    e.at = c + PULSE_OFS;
    e.err = !stop_bit;
    e.data = b;
    ev_q.push_back(e);
    busy_lo = c + 3;
    busy_hi = stop_bit ? c + PULSE_OFS - 1 : (1 << 30);
    rx_serial = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      waitCycles(CPB);
    end
    rx_serial = stop_bit;
    waitCycles(CPB);
  endtask

  task automatic checkCaptured(input string name);
    checkOutput({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput({name, "_byte"}, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
    end
  endtask

  // Per-cycle comparison against the scheduled-event model.
  always @(negedge clk) begin
    if (check_en) begin
      exp_valid = 1'b0;
      exp_ferr = 1'b0;
      if (rst_was) model_data = 8'h00;
      if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        if (ev_q[0].err) exp_ferr = 1'b1;
        else begin
          exp_valid = 1'b1;
          model_data = ev_q[0].data;
        end
        void'(ev_q.pop_front());
      end
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      checkOutput("rx_valid", rx_valid, exp_valid);
      checkOutput("frame_error", frame_error, exp_ferr);
      checkOutput("busy", busy, exp_busy);
      checkOutput("rx_data", rx_data, model_data);
      if (rx_valid) begin
        got_q.push_back(rx_data);
        n_valid++;
      end
      if (frame_error) n_ferr++;
    end
    rst_was = rst;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    int nv0, nf0;
    rst = 1'b1;
    rx_serial = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    checkOutput("reset_data", rx_data, 8'h00);
    checkOutput("reset_valid", rx_valid, 1'b0);
    checkOutput("reset_ferr", frame_error, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    check_en = 1'b1;
    waitCycles(5);

    $display("[TB] single byte 0x55");
    got_q.delete();
    applyStimulus(8'h55, 1'b1);
    waitCycles(4);
    exp_q = {8'h55};
    checkCaptured("single");
    checkOutput("single_busy", busy, 1'b0);

    $display("[TB] back-to-back instruction bytes");
    got_q.delete();
    exp_q = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    for (int i = 0; i < 8; i++) applyStimulus(exp_q[i], 1'b1);
    waitCycles(4);
    checkCaptured("b2b");

    $display("[TB] glitch");
    nv0 = n_valid;
    nf0 = n_ferr;
    c = cyc;
    busy_lo = c + 3;
    busy_hi = c + 3 + HALF - 1;
    rx_serial = 1'b0;
    waitCycles(4);
    rx_serial = 1'b1;
    waitCycles(10);
    checkOutput("glitch_busy", busy, 1'b0);
    waitCycles(10);
    checkOutput("glitch_valid", n_valid - nv0, 0);
    checkOutput("glitch_ferr", n_ferr - nf0, 0);

    $display("[TB] extremes 0x00 and 0xFF");
    got_q.delete();
    nf0 = n_ferr;
    applyStimulus(8'h00, 1'b1);
    checkOutput("ext_data0", rx_data, 8'h00);
    applyStimulus(8'hFF, 1'b1);
    waitCycles(4);
    checkOutput("ext_data1", rx_data, 8'hFF);
    exp_q = {8'h00, 8'hFF};
    checkCaptured("ext");
    checkOutput("ext_ferr", n_ferr - nf0, 0);

    $display("[TB] frame error on 0xA5");
    nv0 = n_valid;
    nf0 = n_ferr;
    applyStimulus(8'hA5, 1'b0);
    waitCycles(40);
    checkOutput("ferr_busy_low_line", busy, 1'b1);
    busy_hi = cyc + 2;
    rx_serial = 1'b1;
    waitCycles(20);
    checkOutput("ferr_count", n_ferr - nf0, 1);
    checkOutput("ferr_no_valid", n_valid - nv0, 0);
    checkOutput("ferr_data_kept", rx_data, 8'hFF);
    checkOutput("ferr_busy_after", busy, 1'b0);
    got_q.delete();
    applyStimulus(8'h3C, 1'b1);
    waitCycles(4);
    exp_q = {8'h3C};
    checkCaptured("after_ferr");

    $display("[TB] reset mid-frame");
    nv0 = n_valid;
    c = cyc;
    busy_lo = c + 3;
    busy_hi = 1 << 30;
    rx_serial = 1'b0;
    waitCycles(CPB);
    rx_serial = 1'b1;
    waitCycles(3 * CPB + 6);
    rst = 1'b1;
    busy_hi = cyc;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("midrst_data", rx_data, 8'h00);
    checkOutput("midrst_valid", rx_valid, 1'b0);
    checkOutput("midrst_ferr", frame_error, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    waitCycles(120);
    checkOutput("midrst_no_pulse", n_valid - nv0, 0);
    got_q.delete();
    applyStimulus(8'h81, 1'b1);
    waitCycles(4);
    exp_q = {8'h81};
    checkCaptured("after_rst");
    checkOutput("final_data", rx_data, 8'h81);
    checkOutput("events_drained", ev_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
